jacobi_loader: RTL

JACOBI_LOADER -- requirements
Module: jacobi_loader

---
 rtl/jacobi_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/jacobi_loader.sv
// jacobi_loader
// Receives a word stream from upstream (N, iteration limit, threshold, then the
// N*N matrix, the N-entry b vector and the N-entry initial x vector), writes the
// data words into RAM at consecutive addresses, latches the configuration, and
// starts the Jacobi solver once the whole system is in RAM.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_data is the 32-bit word
//   ram_wren/addr/wdata   RAM write port, one write per accepted data word
//   cfg_n/iter/thresh     latched system order, iteration limit, threshold
//   solver_go             one-cycle start pulse to the solver
//   solver_done           one-cycle completion pulse from the solver
//   busy                  high whenever the loader is not idle in S_N
//   err                   sticky flag for an illegal system order
module jacobi_loader #(
  parameter int N_MAX  = 64,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [7:0]        cfg_n,
  output logic [31:0]       cfg_iter,
  output logic [31:0]       cfg_thresh,
  output logic              solver_go,
  input  logic              solver_done,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_N, S_IT, S_TH, S_LOAD, S_GO, S_WAIT, S_ERR
  } state_t;

  state_t state, state_next;

  // N*N+2N never exceeds 8280 for N <= 90, so 16 bits covers counter and total.
  logic [15:0] word_cnt;
  logic [15:0] total;
  logic        accept;
  logic        n_ok;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign n_ok      = (in_data != 32'd0) && (in_data <= 32'(N_MAX));
  assign last_word = (word_cnt == total - 16'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_N;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: header words advance one state each, the data phase
  // ends on the last of the T words, and S_ERR is only left through reset.
  always_comb begin
    state_next = state;
    case (state)
      S_N:     if (accept) state_next = n_ok ? S_IT : S_ERR;
      S_IT:    if (accept) state_next = S_TH;
      S_TH:    if (accept) state_next = S_LOAD;
      S_LOAD:  if (accept && last_word) state_next = S_GO;
      S_GO:    state_next = S_WAIT;
      S_WAIT:  if (solver_done) state_next = S_N;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_N;
    endcase
  end

  // Outputs that depend only on the current state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    err      = 1'b0;
    case (state)
      S_N:     begin in_ready = 1'b1; busy = 1'b0; end
      S_IT,
      S_TH,
      S_LOAD:  in_ready = 1'b1;
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  // Registered datapath. The RAM write lands one cycle after acceptance, so
  // the last write occupies the single S_GO cycle; solver_go is registered off
  // S_GO so that it pulses in the cycle right after that last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt   <= '0;
      total      <= '0;
      ram_wren   <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cfg_n      <= '0;
      cfg_iter   <= '0;
      cfg_thresh <= '0;
      solver_go  <= 1'b0;
    end else begin
      ram_wren  <= 1'b0;
      solver_go <= (state == S_GO);
      if (accept) begin
        case (state)
          S_N:    if (n_ok) cfg_n <= in_data[7:0];
          S_IT:   cfg_iter <= in_data;
          S_TH: begin
            cfg_thresh <= in_data;
            word_cnt   <= '0;
            total      <= ({8'd0, cfg_n} * {8'd0, cfg_n}) + {7'd0, cfg_n, 1'b0};
          end
          S_LOAD: begin
            ram_wren  <= 1'b1;
            ram_addr  <= ADDR_W'(word_cnt);
            ram_wdata <= in_data;
            word_cnt  <= word_cnt + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
